// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-keyboard PS/2 command transmitter.
// Inhibits the clock, issues a start bit and clocks out data, parity and stop, then checks the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic       clk25,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       PS2_Clk,
    input  logic       PS2_Data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    typedef enum logic [2:0] {IDLE, INHIBIT, START, SHIFT, ACK, RELEASE} state_t;
    localparam logic [18:0] INH_LAST = 19'(INHIBIT_CYCLES - 1);
    localparam logic [18:0] TMO = 19'(TIMEOUT_CYCLES);
    state_t state, state_nx;
    logic [2:0] clk_sy;
    logic [1:0] dat_sy;
    logic [9:0] sr;
    logic [3:0] bit_cnt;
    logic [18:0] cnt;
    logic drv, fall, timed, timeout;
    // clk_sy[1] is the synced level, clk_sy[2] its previous sample
    assign fall = clk_sy[2] & ~clk_sy[1];
    assign timed = state inside {SHIFT, ACK, RELEASE};
    assign timeout = timed && cnt >= TMO;
    always_ff @(posedge clk25 or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = tx_start ? INHIBIT : IDLE;
            INHIBIT: state_nx = cnt == INH_LAST ? START : INHIBIT;
            START:   state_nx = SHIFT;
            SHIFT:   state_nx = timeout ? IDLE : (fall && bit_cnt == 4'd9) ? ACK : SHIFT;
            ACK:     state_nx = timeout ? IDLE : fall ? (dat_sy[1] ? IDLE : RELEASE) : ACK;
            RELEASE: state_nx = (timeout || (clk_sy[1] && dat_sy[1])) ? IDLE : RELEASE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        tx_busy = state != IDLE;
        ps2_clk_oe = state inside {INHIBIT, START};
        ps2_data_oe = state == START || (state == SHIFT && drv && !timeout);
        tx_error = timeout || (state == ACK && fall && dat_sy[1]);
        tx_done = state == RELEASE && !timeout && clk_sy[1] && dat_sy[1];
    end
    // frame register holds {stop, odd parity, data}; shifted out LSB first
    always_ff @(posedge clk25 or negedge reset_n)
        if (!reset_n) begin
            clk_sy <= '1;
            dat_sy <= '1;
            sr <= '0;
            bit_cnt <= '0;
            cnt <= '0;
            drv <= 1'b0;
        end else begin
            clk_sy <= {clk_sy[1:0], PS2_Clk};
            dat_sy <= {dat_sy[0], PS2_Data};
            if (state == IDLE && tx_start) begin
                sr <= {1'b1, ~^tx_data, tx_data};
                cnt <= '0;
            end else if (state == INHIBIT) begin
                cnt <= cnt + 19'd1;
            end else if (state == START) begin
                cnt <= '0;
                bit_cnt <= '0;
                drv <= 1'b1;
            end else if (timed) begin
                cnt <= &cnt ? cnt : cnt + 19'd1;
                if (state == SHIFT && fall) begin
                    drv <= ~sr[0];
                    sr <= {1'b0, sr[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end
        end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives a PS/2 device model against ps2_host_tx and checks frames, timing and pulses.
module tb_ps2_host_tx;
    localparam int INH = 2500;
    localparam int TMO = 4000;
    logic clk25 = 1'b0, reset_n = 1'b0, tx_start = 1'b0, dev_clk = 1'b1, dev_dat = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe, PS2_Clk, PS2_Data;
    int n_cmp = 0, n_fail = 0, n_done = 0, n_err = 0, cyc = 0;
    logic prev_done = 1'b0, prev_err = 1'b0;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk25(clk25), .reset_n(reset_n), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
        .PS2_Clk(PS2_Clk), .PS2_Data(PS2_Data),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    // open-drain wired-AND of device and host
    assign PS2_Clk = dev_clk & ~ps2_clk_oe;
    assign PS2_Data = dev_dat & ~ps2_data_oe;
    always #5 clk25 = ~clk25;
    always @(posedge clk25) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [9:0] frame_of(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, ones % 2 == 0, b};
    endfunction

    always @(negedge clk25) if (reset_n) begin
        chk("done_err_excl", {31'd0, tx_done & tx_error}, 0);
        if (!tx_busy) chk("idle_lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
        if (prev_done) chk("done_one_cycle", {31'd0, tx_done}, 0);
        if (prev_err) chk("err_one_cycle", {31'd0, tx_error}, 0);
        n_done += int'(tx_done);
        n_err += int'(tx_error);
        prev_done = tx_done;
        prev_err = tx_error;
    end

    // mode: 0 device ACKs, 1 device leaves data high, 2 device silent, 3 reset during bit 4
    task automatic send(input logic [7:0] b, input int mode, input int h, input bit restart, input bit late_start);
        logic [9:0] got;
        int n, t0, d0, e0;
        got = '0;
        @(negedge clk25);
        tx_data = b;
        tx_start = 1'b1;
        @(negedge clk25);
        tx_start = 1'b0;
        chk("busy_on_accept", {31'd0, tx_busy}, 1);
        n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < INH + 10) begin
            n++;
            @(negedge clk25);
        end
        chk("inhibit_len", n, INH);
        chk("start_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 3);
        @(negedge clk25);
        chk("release_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 1);
        t0 = cyc;
        d0 = n_done;
        e0 = n_err;
        if (mode == 2) begin
            n = 0;
            while (!tx_error && n < TMO + 10) begin
                @(negedge clk25);
                n++;
            end
            chk("timeout_cycles", cyc - t0, TMO);
            chk("timeout_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
        end else begin
            repeat (4) @(negedge clk25);
            chk("start_bit", {31'd0, PS2_Data}, 0);
            for (int k = 0; k < 10; k++) begin
                dev_clk = 1'b0;
                if (mode == 3 && k == 4) begin
                    #2 reset_n = 1'b0;
                    #1 chk("reset_async_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
                    chk("reset_async_flags", {29'd0, tx_busy, tx_done, tx_error}, 0);
                    @(negedge clk25);
                    reset_n = 1'b1;
                    dev_clk = 1'b1;
                    repeat (4) @(negedge clk25);
                    chk("reset_no_pulse", (n_done - d0) + (n_err - e0), 0);
                    chk("reset_busy_off", {31'd0, tx_busy}, 0);
                    return;
                end
                if (restart && k == 4) begin
                    tx_data = ~b;
                    tx_start = 1'b1;
                end
                @(negedge clk25);
                tx_start = 1'b0;
                repeat (h - 1) @(negedge clk25);
                got[k] = PS2_Data;
                dev_clk = 1'b1;
                repeat (h) @(negedge clk25);
            end
            chk("frame", {22'd0, got}, {22'd0, frame_of(b)});
            if (restart) chk("busy_through_restart", {31'd0, tx_busy}, 1);
            dev_dat = (mode == 1);
            repeat (2) @(negedge clk25);
            dev_clk = 1'b0;
            repeat (h) @(negedge clk25);
            dev_clk = 1'b1;
            repeat (h) @(negedge clk25);
            dev_dat = 1'b1;
            if (mode == 0) begin
                n = 0;
                while (!tx_done && n < 40) begin
                    @(negedge clk25);
                    n++;
                end
                chk("done_seen", {31'd0, tx_done}, 1);
                if (late_start) begin
                    tx_data = 8'h99;
                    tx_start = 1'b1;
                    @(negedge clk25);
                    tx_start = 1'b0;
                    chk("start_on_pulse_ignored", {31'd0, tx_busy}, 0);
                end
            end
        end
        repeat (4) @(negedge clk25);
        chk("busy_off", {31'd0, tx_busy}, 0);
        chk("done_count", n_done - d0, mode == 0 ? 1 : 0);
        chk("err_count", n_err - e0, mode == 0 ? 0 : 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk25);
        chk("reset_outputs", {27'd0, tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe}, 0);
        chk("model_frame_ed", {22'd0, frame_of(8'hED)}, {22'd0, 10'b11_1110_1101});
        chk("model_frame_00", {22'd0, frame_of(8'h00)}, {22'd0, 10'b11_0000_0000});
        chk("model_frame_01", {22'd0, frame_of(8'h01)}, {22'd0, 10'b10_0000_0001});
        reset_n = 1'b1;
        repeat (2) @(negedge clk25);
        chk("idle_after_reset", {27'd0, tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe}, 0);
        send(8'hED, 0, 8, 1'b0, 1'b1);
        send(8'h00, 0, 7, 1'b0, 1'b0);
        send(8'h5A, 1, 8, 1'b0, 1'b0);
        send(8'hAA, 2, 8, 1'b0, 1'b0);
        send(8'h3C, 0, 9, 1'b1, 1'b0);
        send(8'h77, 3, 8, 1'b0, 1'b0);
        send(8'hF4, 0, 8, 1'b0, 1'b0);
        for (int r = 0; r < 6; r++)
            send(8'($urandom), $urandom_range(0, 3) == 0 ? 1 : 0, int'($urandom_range(6, 12)), 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
